mux_arbiter: RTL and testbench

- Two-requester arbiter that shares one LEN_DATA-wide data path between sources A and B, each with a valid/ready handshake.
- Picks a source, drives the 2-to-1 mux select, and registers the selected beat into a single output stage.
- Supports multi-beat bursts: the grant is locked to one source until its last beat is accepted.
- Sits between producer engines and the shared consumer bus of the processing element.

---
 rtl/mux_arbiter_pkg.sv | 13 +
 rtl/mux_arbiter_mux.sv | 13 +
 rtl/mux_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mux_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arbiter_pkg.sv
// Shared definitions for the two-source burst arbiter: FSM state encoding and source IDs.
package mux_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB     = 2'd0,
    BURST_A = 2'd1,
    BURST_B = 2'd2
  } state_e;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/mux_arbiter_mux.sv
// Plain 2-to-1 data multiplexer; s=0 selects a, s=1 selects b.
module mux_arbiter_mux #(
  parameter int LEN_DATA = 256
) (
  input  logic                s,
  input  logic [LEN_DATA-1:0] a,
  input  logic [LEN_DATA-1:0] b,
  output logic [LEN_DATA-1:0] y
);

  assign y = s ? b : a;

endmodule

// File: rtl/mux_arbiter.sv
// Two-source round-robin arbiter with burst locking and a single registered output stage.
// Optional per-source beat counters are built when MUX_ARBITER_PERF_CNT_EN is defined.
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int LEN_DATA = 256,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [LEN_DATA-1:0] a_data,
  input  logic                a_last,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [LEN_DATA-1:0] b_data,
  input  logic                b_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LEN_DATA-1:0] out_data,
  output logic                out_last,
  output logic                out_src,
`ifdef MUX_ARBITER_PERF_CNT_EN
  input  logic                cnt_clr,
  output logic [CNT_W-1:0]    cnt_a,
  output logic [CNT_W-1:0]    cnt_b,
`endif
  output logic                locked
);

  state_e              state_r;
  state_e              state_nxt_s;
  logic                rr_last_r;
  logic                out_valid_r;
  logic [LEN_DATA-1:0] out_data_r;
  logic                out_last_r;
  logic                out_src_r;
  logic                locked_r;

  logic                load_s;
  logic                grant_a_s;
  logic                grant_b_s;
  logic                sel_s;
  logic                accept_s;
  logic                sel_last_s;
  logic [LEN_DATA-1:0] mux_data_s;

  // The output stage can take a new beat when empty or when it drains this cycle.
  assign load_s     = ~out_valid_r | out_ready;
  assign sel_s      = grant_b_s;
  assign a_ready    = load_s & grant_a_s;
  assign b_ready    = load_s & grant_b_s;
  assign accept_s   = a_ready | b_ready;
  assign sel_last_s = sel_s ? b_last : a_last;

  mux_arbiter_mux #(
    .LEN_DATA (LEN_DATA)
  ) u_mux (
    .s (sel_s),
    .a (a_data),
    .b (b_data),
    .y (mux_data_s)
  );

  // Grant selection: round-robin on ties in ARB, locked source only during a burst.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    case (state_r)
      ARB: begin
        if (a_valid && b_valid) begin
          grant_a_s = (rr_last_r == SRC_B);
          grant_b_s = (rr_last_r == SRC_A);
        end else begin
          grant_a_s = a_valid;
          grant_b_s = b_valid;
        end
      end
      BURST_A: grant_a_s = a_valid;
      BURST_B: grant_b_s = b_valid;
      default: begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
      end
    endcase
  end

  // Next state: moves only on an accepted beat; an undefined encoding recovers to ARB.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ARB, BURST_A, BURST_B: begin
        if (accept_s) begin
          if (sel_last_s) begin
            state_nxt_s = ARB;
          end else if (sel_s == SRC_B) begin
            state_nxt_s = BURST_B;
          end else begin
            state_nxt_s = BURST_A;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = ARB;
    endcase
  end

  // FSM, round-robin memory and the output register stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ARB;
      rr_last_r   <= SRC_B;
      locked_r    <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_last_r  <= 1'b0;
      out_src_r   <= SRC_A;
    end else begin
      state_r  <= state_nxt_s;
      locked_r <= (state_nxt_s != ARB);
      if (accept_s && sel_last_s) begin
        rr_last_r <= sel_s;
      end
      if (load_s) begin
        if (accept_s) begin
          out_valid_r <= 1'b1;
          out_data_r  <= mux_data_s;
          out_last_r  <= sel_last_s;
          out_src_r   <= sel_s;
        end else begin
          out_valid_r <= 1'b0;
        end
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;
  assign out_src   = out_src_r;
  assign locked    = locked_r;

`ifdef MUX_ARBITER_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_a_r;
  logic [CNT_W-1:0] cnt_b_r;

  // Saturating accepted-beat counters; a clear takes priority over a same-cycle accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_a_r <= '0;
      cnt_b_r <= '0;
    end else if (cnt_clr) begin
      cnt_a_r <= '0;
      cnt_b_r <= '0;
    end else begin
      if (a_ready && (cnt_a_r != CNT_MAX)) begin
        cnt_a_r <= cnt_a_r + CNT_ONE;
      end
      if (b_ready && (cnt_b_r != CNT_MAX)) begin
        cnt_b_r <= cnt_b_r + CNT_ONE;
      end
    end
  end

  assign cnt_a = cnt_a_r;
  assign cnt_b = cnt_b_r;
`endif

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter: directed scenarios plus random traffic against a
// transaction-level model; output beats are checked by a scoreboard monitor.
module tb_mux_arbiter;

  localparam int LEN_DATA = 256;
  localparam int CNT_W    = 32;

  typedef struct {
    logic [LEN_DATA-1:0] data;
    bit                  last;
    bit                  src;
  } beat_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                a_valid = 1'b0, b_valid = 1'b0;
  logic                a_last = 1'b0, b_last = 1'b0;
  logic [LEN_DATA-1:0] a_data = '0, b_data = '0;
  logic                out_ready = 1'b0;
  logic                a_ready, b_ready, out_valid, out_last, out_src, locked;
  logic [LEN_DATA-1:0] out_data;
  logic                cnt_clr = 1'b0;
`ifdef MUX_ARBITER_PERF_CNT_EN
  logic [CNT_W-1:0]    cnt_a, cnt_b;
`endif

  mux_arbiter #(.LEN_DATA(LEN_DATA), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_data    (a_data),
    .a_last    (a_last),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_data    (b_data),
    .b_last    (b_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src),
`ifdef MUX_ARBITER_PERF_CNT_EN
    .cnt_clr   (cnt_clr),
    .cnt_a     (cnt_a),
    .cnt_b     (cnt_b),
`endif
    .locked    (locked)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: which source owns an open burst (-1 none), who last finished a
  // transfer, whether the output holds a beat and what it is, and beats per source.
  int      owner = -1;
  bit      last_winner = 1'b1;
  bit      full = 1'b0;
  beat_t   cur;
  beat_t   sb[$];
  longint  n_a = 0, n_b = 0;

  task automatic chk(input string name, input logic [LEN_DATA-1:0] act,
                     input logic [LEN_DATA-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [LEN_DATA-1:0] rnd_data();
    logic [LEN_DATA-1:0] d;
    for (int i = 0; i < LEN_DATA / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // One clock of stimulus: drive at negedge, check the model's view, then advance the model.
  task automatic cycle(input bit av, input logic [LEN_DATA-1:0] ad, input bit al,
                       input bit bv, input logic [LEN_DATA-1:0] bd, input bit bl,
                       input bit ordy, input bit clr);
    bit load, want_a, want_b;
    beat_t nb;
    @(negedge clk);
    a_valid = av; a_data = ad; a_last = al;
    b_valid = bv; b_data = bd; b_last = bl;
    out_ready = ordy; cnt_clr = clr;
    #1;
    chk("out_valid", out_valid, full);
    chk("locked", locked, owner != -1);
    if (full) begin
      chk("out_data_held", out_data, cur.data);
      chk("out_src_held", out_src, cur.src);
      chk("out_last_held", out_last, cur.last);
    end
`ifdef MUX_ARBITER_PERF_CNT_EN
    chk("cnt_a", cnt_a, n_a[CNT_W-1:0]);
    chk("cnt_b", cnt_b, n_b[CNT_W-1:0]);
`endif
    load = !full || ordy;
    if (owner == 0)      begin want_a = av; want_b = 1'b0; end
    else if (owner == 1) begin want_a = 1'b0; want_b = bv; end
    else if (av && bv)   begin want_a = last_winner; want_b = !last_winner; end
    else                 begin want_a = av; want_b = bv; end
    want_a = want_a && load;
    want_b = want_b && load;
    chk("a_ready", a_ready, want_a);
    chk("b_ready", b_ready, want_b);
    if (want_a || want_b) begin
      nb.src  = want_b;
      nb.data = want_b ? bd : ad;
      nb.last = want_b ? bl : al;
      sb.push_back(nb);
      cur  = nb;
      full = 1'b1;
      if (nb.last) begin owner = -1; last_winner = nb.src; end
      else owner = nb.src;
    end else if (load) begin
      full = 1'b0;
    end
    if (clr) begin n_a = 0; n_b = 0; end
    else if (want_a) n_a++;
    else if (want_b) n_b++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    owner = -1; last_winner = 1'b1; full = 1'b0; n_a = 0; n_b = 0;
    sb.delete();
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_src", out_src, 1'b0);
  endtask

  // Scoreboard monitor: every output handshake must match the oldest expected beat.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_unexpected actual=src%0d expected=no_beat", out_src);
        end else begin
          e = sb.pop_front();
          chk("sb_data", out_data, e.data);
          chk("sb_last", out_last, e.last);
          chk("sb_src", out_src, e.src);
        end
      end
    end
  end

  logic [LEN_DATA-1:0] d1, d2, d3, z;

  initial begin
    z = '0;
    d1 = '0; d1[7:0] = 8'h11;
    d2 = '0; d2[7:0] = 8'h22;
    d3 = '0; d3[7:0] = 8'h33;
    do_reset();

    // Ties with single-beat transfers alternate A, B, A, B.
    for (int i = 0; i < 4; i++) cycle(1'b1, rnd_data(), 1'b1, 1'b1, rnd_data(), 1'b1, 1'b1, 1'b0);
    cycle(1'b0, z, 1'b0, 1'b0, z, 1'b0, 1'b1, 1'b0);

    // Three-beat A burst while B waits; B is granted after A's last beat.
    cycle(1'b1, d1, 1'b0, 1'b1, rnd_data(), 1'b1, 1'b1, 1'b0);
    cycle(1'b1, d2, 1'b0, 1'b1, rnd_data(), 1'b1, 1'b1, 1'b0);
    cycle(1'b1, d3, 1'b1, 1'b1, rnd_data(), 1'b1, 1'b1, 1'b0);
    cycle(1'b1, rnd_data(), 1'b1, 1'b1, rnd_data(), 1'b1, 1'b1, 1'b0);

    // Output stall with both sources valid: nothing accepted, output held.
    for (int i = 0; i < 5; i++) cycle(1'b1, rnd_data(), 1'b1, 1'b1, rnd_data(), 1'b1, 1'b0, 1'b0);
    cycle(1'b0, z, 1'b0, 1'b0, z, 1'b0, 1'b1, 1'b0);

    // Mid-burst gap on A: B must stall while the burst stays locked.
    cycle(1'b1, d1, 1'b0, 1'b0, z, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, z, 1'b0, 1'b1, rnd_data(), 1'b1, 1'b1, 1'b0);
    cycle(1'b1, d2, 1'b1, 1'b1, rnd_data(), 1'b1, 1'b1, 1'b0);
    cycle(1'b0, z, 1'b0, 1'b0, z, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a B burst, then a tie goes to A.
    cycle(1'b0, z, 1'b0, 1'b1, d3, 1'b0, 1'b1, 1'b0);
    do_reset();
    cycle(1'b1, d1, 1'b1, 1'b1, d2, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, z, 1'b0, 1'b0, z, 1'b0, 1'b1, 1'b0);

`ifdef MUX_ARBITER_PERF_CNT_EN
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, rnd_data(), 1'b1, 1'b0, z, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++)  cycle(1'b0, z, 1'b0, 1'b1, rnd_data(), 1'b1, 1'b1, 1'b0);
    cycle(1'b0, z, 1'b0, 1'b0, z, 1'b0, 1'b1, 1'b0);
    chk("cnt_a_10", cnt_a, 10);
    chk("cnt_b_7", cnt_b, 7);
    cycle(1'b1, rnd_data(), 1'b1, 1'b0, z, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, z, 1'b0, 1'b0, z, 1'b0, 1'b1, 1'b0);
    chk("cnt_a_clr", cnt_a, 0);
    chk("cnt_b_clr", cnt_b, 0);
`endif

    // Random traffic with random bursts and back-pressure.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, rnd_data(), $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) != 0, rnd_data(), $urandom_range(0, 2) == 0,
            $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);

    // Drain the output stage and confirm every expected beat was seen.
    for (int i = 0; i < 3; i++) cycle(1'b0, z, 1'b0, 1'b0, z, 1'b0, 1'b1, 1'b0);
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
